// File: rtl/io_tile_pkg.sv
// Shared definitions for the I/O logical tile: per-channel config bit
// layout and load-tracking FSM state encodings.
package io_tile_pkg;

   // Each pad channel owns three consecutive configuration flops.
   localparam int CFG_BITS_PER_IO = 3;
   localparam int CFG_DIR         = 0;  // 1 = pad drives out
   localparam int CFG_INV         = 1;  // invert data in both directions
   localparam int CFG_HOLD        = 2;  // keep last input value while gated

   // Load-progress tracking for the configuration chain segment.
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      LOADED  = 2'd2
   } cfg_state_e;

endpackage

// File: rtl/io_chan_ctrl.sv
// One pad channel: gates fabric/pad data on the tile's active flag and
// remembers the last live input so it can be presented while gated.
module io_chan_ctrl (
   input  logic prog_clk,
   input  logic prog_reset_n,
   input  logic active,
   input  logic cfg_dir,
   input  logic cfg_inv,
   input  logic cfg_hold,
   input  logic io_outpad,
   input  logic soc_in,
   output logic io_inpad,
   output logic soc_out,
   output logic soc_dir
);

   logic held_q;
   logic held_d;
   logic in_val;

   // Capture the (polarity-corrected) pad input only while it is live.
   always_comb begin
      in_val = soc_in ^ cfg_inv;
      held_d = held_q;
      if (active && !cfg_dir) begin
         held_d = in_val;
      end
   end

   // Pad gating: nothing leaves or enters the fabric until the tile is active.
   always_comb begin
      soc_dir  = active & cfg_dir;
      soc_out  = active & cfg_dir & (io_outpad ^ cfg_inv);
      io_inpad = active ? (~cfg_dir & in_val) : (cfg_hold & held_q);
   end

   // Held-value flop.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         held_q <= 1'b0;
      end else begin
         held_q <= held_d;
      end
   end

endmodule

// File: rtl/logical_tile_io_array_cfg.sv
// Multi-channel I/O logical tile: one configuration chain segment feeding
// NUM_IO pad channels, with load tracking and safe gating until the chain
// holds exactly one complete configuration.
module logical_tile_io_array_cfg #(
   parameter int NUM_IO = 4
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              isol_n,
   input  logic              ccff_en,
   input  logic              ccff_head,
   output logic              ccff_tail,
   output logic              cfg_done,
   output logic              cfg_ovf,
   input  logic [NUM_IO-1:0] io_outpad,
   output logic [NUM_IO-1:0] io_inpad,
   input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
   output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
   output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir
);

   import io_tile_pkg::*;

   localparam int CHAIN_LEN = NUM_IO * CFG_BITS_PER_IO;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   cfg_state_e           state_q, state_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;
   logic                 active;

   // Serial shift: first bit in ends up at the far end of the chain.
   always_comb begin
      cfg_d = cfg_q;
      if (ccff_en) begin
         cfg_d = {cfg_q[CHAIN_LEN-2:0], ccff_head};
      end
   end

   // Load tracking: count shifts, flag overshift, declare done only once
   // the chain goes idle holding exactly CHAIN_LEN fresh bits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         EMPTY: begin
            if (ccff_en) begin
               state_d = LOADING;
               cnt_d   = CNT_ONE;
            end
         end
         LOADING: begin
            if (ccff_en) begin
               if (cnt_q < CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d = LOADED;
            end
         end
         LOADED: begin
            if (ccff_en) begin
               state_d = LOADING;
               cnt_d   = CNT_ONE;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = EMPTY;
            cnt_d   = '0;
         end
      endcase
      // Done drops on the same edge the first reload bit shifts in, so pads
      // never see a partially shifted configuration.
      done_d = (state_d == LOADED);
   end

   // Chain, counter, FSM state and registered status outputs.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         cfg_q   <= '0;
         cnt_q   <= '0;
         state_q <= EMPTY;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cfg_q   <= cfg_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign ccff_tail = cfg_q[CHAIN_LEN-1];
   assign cfg_done  = done_q;
   assign cfg_ovf   = ovf_q;
   assign active    = done_q & isol_n;

   for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_chan
      io_chan_ctrl u_chan (
         .prog_clk     (prog_clk),
         .prog_reset_n (prog_reset_n),
         .active       (active),
         .cfg_dir      (cfg_q[gi*CFG_BITS_PER_IO + CFG_DIR]),
         .cfg_inv      (cfg_q[gi*CFG_BITS_PER_IO + CFG_INV]),
         .cfg_hold     (cfg_q[gi*CFG_BITS_PER_IO + CFG_HOLD]),
         .io_outpad    (io_outpad[gi]),
         .soc_in       (gfpga_pad_io_soc_in[gi]),
         .io_inpad     (io_inpad[gi]),
         .soc_out      (gfpga_pad_io_soc_out[gi]),
         .soc_dir      (gfpga_pad_io_soc_dir[gi])
      );
   end

endmodule

// File: tb/tb_logical_tile_io_array_cfg.sv
// Directed bench for the I/O logical tile (NUM_IO=4, CHAIN_LEN=12).
module tb_logical_tile_io_array_cfg;

   logic       prog_clk;
   logic       prog_reset_n;
   logic       isol_n;
   logic       ccff_en;
   logic       ccff_head;
   logic       ccff_tail;
   logic       cfg_done;
   logic       cfg_ovf;
   logic [3:0] io_outpad;
   logic [3:0] io_inpad;
   logic [3:0] soc_in;
   logic [3:0] soc_out;
   logic [3:0] soc_dir;

   int checks = 0;
   int errors = 0;

   logic [12:0] ovr_seq;
   logic [11:0] cfg_a;
   logic [11:0] cfg_b;
   logic [11:0] cfg_c;

   logical_tile_io_array_cfg #(.NUM_IO(4)) dut (
      .prog_clk             (prog_clk),
      .prog_reset_n         (prog_reset_n),
      .isol_n               (isol_n),
      .ccff_en              (ccff_en),
      .ccff_head            (ccff_head),
      .ccff_tail            (ccff_tail),
      .cfg_done             (cfg_done),
      .cfg_ovf              (cfg_ovf),
      .io_outpad            (io_outpad),
      .io_inpad             (io_inpad),
      .gfpga_pad_io_soc_in  (soc_in),
      .gfpga_pad_io_soc_out (soc_out),
      .gfpga_pad_io_soc_dir (soc_dir)
   );

   // Clock and reset
   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   // Shift v[hi] first down to v[lo], one bit per clock, then idle the chain.
   task automatic shift_bits(input logic [15:0] v, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         ccff_en   = 1'b1;
         ccff_head = v[i];
         tick();
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   task automatic mid_cycle_reset();
      @(posedge prog_clk);
      #3;
      prog_reset_n = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      #2;
      prog_reset_n = 1'b1;
      tick();
   endtask

   initial begin
      prog_reset_n = 1'b0;
      isol_n       = 1'b1;
      ccff_en      = 1'b0;
      ccff_head    = 1'b0;
      io_outpad    = 4'b0000;
      soc_in       = 4'b0000;
      cfg_a        = 12'b000_000_011_001;
      cfg_b        = 12'b000_100_011_001;
      cfg_c        = 12'b000_001_000_010;
      ovr_seq      = 13'b0_100_000_011_001;

      // Reset state
      #2;
      check("rst_done", cfg_done, 1'b0);
      check("rst_tail", ccff_tail, 1'b0);
      check("rst_ovf", cfg_ovf, 1'b0);
      check("rst_dir", soc_dir, 4'b0000);
      check("rst_out", soc_out, 4'b0000);
      #10;
      prog_reset_n = 1'b1;
      tick();

      // Full load: ch0 out, ch1 out inverted
      io_outpad = 4'b0011;
      shift_bits({4'b0, cfg_a}, 11, 0);
      check("load_done_early", cfg_done, 1'b0);
      tick();
      check("load_done", cfg_done, 1'b1);
      check("load_dir", soc_dir, 4'b0011);
      check("load_out", soc_out, 4'b0001);
      check("load_tail", ccff_tail, 1'b0);
      check("load_ovf", cfg_ovf, 1'b0);

      // Input path
      soc_in = 4'b1100;
      #1;
      check("in_1100", io_inpad, 4'b1100);
      soc_in = 4'b0011;
      #1;
      check("in_0011", io_inpad, 4'b0000);
      isol_n = 1'b0;
      #1;
      check("isol_dir", soc_dir, 4'b0000);
      check("isol_out", soc_out, 4'b0000);
      isol_n = 1'b1;

      // Hold / isolate: ch2 input with hold
      shift_bits({4'b0, cfg_b}, 11, 0);
      tick();
      check("hold_done", cfg_done, 1'b1);
      soc_in = 4'b0100;
      tick();
      isol_n = 1'b0;
      #1;
      check("hold_inpad", io_inpad, 4'b0100);
      check("hold_dir", soc_dir, 4'b0000);
      soc_in = 4'b0000;
      tick();
      check("hold_keep", io_inpad, 4'b0100);
      isol_n = 1'b1;
      #1;
      check("hold_live0", io_inpad, 4'b0000);
      soc_in = 4'b1100;
      #1;
      check("hold_live1", io_inpad, 4'b1100);

      // Overshift: 13 consecutive shifts
      soc_in = 4'b0000;
      shift_bits({3'b0, ovr_seq}, 12, 1);
      check("ovr_ovf12", cfg_ovf, 1'b0);
      check("ovr_done12", cfg_done, 1'b0);
      check("ovr_tail12", ccff_tail, 1'b0);
      shift_bits({3'b0, ovr_seq}, 0, 0);
      check("ovr_ovf13", cfg_ovf, 1'b1);
      check("ovr_tail13", ccff_tail, 1'b1);
      tick();
      check("ovr_done", cfg_done, 1'b1);
      check("ovr_sticky", cfg_ovf, 1'b1);
      check("ovr_dir", soc_dir, 4'b0011);
      check("ovr_out", soc_out, 4'b0001);

      // Asynchronous reset mid-cycle while configured
      mid_cycle_reset();
      check("arst_done", cfg_done, 1'b0);
      check("arst_tail", ccff_tail, 1'b0);
      check("arst_ovf", cfg_ovf, 1'b0);
      check("arst_dir", soc_dir, 4'b0000);
      check("arst_out", soc_out, 4'b0000);
      check("arst_in", io_inpad, 4'b0000);
      release_reset();

      // Partial load then completion
      io_outpad = 4'b1111;
      soc_in    = 4'b0000;
      shift_bits({4'b0, cfg_c}, 11, 5);
      check("part_done", cfg_done, 1'b0);
      check("part_dir", soc_dir, 4'b0000);
      check("part_out", soc_out, 4'b0000);
      repeat (5) tick();
      check("part_idle_done", cfg_done, 1'b0);
      check("part_idle_dir", soc_dir, 4'b0000);
      shift_bits({4'b0, cfg_c}, 4, 0);
      tick();
      check("part_fin_done", cfg_done, 1'b1);
      check("part_fin_dir", soc_dir, 4'b0100);
      check("part_fin_out", soc_out, 4'b0100);
      check("part_fin_in0", io_inpad, 4'b0001);
      soc_in = 4'b1011;
      #1;
      check("part_fin_in1", io_inpad, 4'b1010);

      // Reset mid-load requires a fresh full load
      shift_bits({4'b0, cfg_c}, 11, 6);
      mid_cycle_reset();
      release_reset();
      shift_bits({4'b0, cfg_c}, 5, 0);
      tick();
      check("rml_done", cfg_done, 1'b0);
      check("rml_dir", soc_dir, 4'b0000);
      shift_bits({4'b0, cfg_c}, 11, 0);
      tick();
      check("rml_full_done", cfg_done, 1'b1);
      check("rml_full_dir", soc_dir, 4'b0100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
